// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: 4-digit seven-segment scan controller with frame-boundary double buffering.
// Define SSD_LZB_EN to enable leading-zero blanking.
module ssd_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic [15:0] val,
    input  logic        on,
    output logic        pend,
    output logic [1:0]  tr,
    output logic [3:0]  digit,
    output logic        en
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    tr_nx;
    logic [15:0]   shadow, disp, disp_nx;
    logic          wrap, frame, blank;

    always_comb begin
        wrap    = cnt == LAST;
        frame   = wrap && tr == 2'd3;
        cnt_nx  = wrap ? '0 : cnt + CW'(1);
        tr_nx   = wrap ? tr + 2'd1 : tr;
        // a load on the boundary edge bypasses the shadow and lands directly
        disp_nx = !frame ? disp : ld ? val : pend ? shadow : disp;
`ifdef SSD_LZB_EN
        blank   = tr_nx == 2'd3 ? disp_nx[15:12] == 4'd0 :
                  tr_nx == 2'd2 ? disp_nx[15:8] == 8'd0 :
                  tr_nx == 2'd1 ? disp_nx[15:4] == 12'd0 : 1'b0;
`else
        blank   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tr     <= '0;
            shadow <= '0;
            disp   <= '0;
            pend   <= 1'b0;
            digit  <= '0;
            en     <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            tr     <= tr_nx;
            disp   <= disp_nx;
            if (ld) shadow <= val;
            pend   <= frame ? 1'b0 : (pend | ld);
            digit  <= disp_nx[{tr_nx, 2'b00} +: 4];
            en     <= on && cnt_nx >= BLK && !blank;
        end
    end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed bench for ssd_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1.
// Expected EN accounts for leading-zero blanking when SSD_LZB_EN is defined.
module tb_ssd_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] val = '0;
    logic        on = 1'b1;
    logic        pend;
    logic [1:0]  tr;
    logic [3:0]  digit;
    logic        en;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n = 0;

    ssd_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .ld(ld), .val(val), .on(on),
        .pend(pend), .tr(tr), .digit(digit), .en(en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic logic exp_en(input int k, input logic o, input logic [15:0] d);
        int c, t;
        logic b;
        c = k % 4;
        t = (k / 4) % 4;
        b = 1'b0;
`ifdef SSD_LZB_EN
        b = t == 3 ? d[15:12] == 4'd0 : t == 2 ? d[15:8] == 8'd0 : t == 1 ? d[15:4] == 12'd0 : 1'b0;
`endif
        return o && c != 0 && !b;
    endfunction

    // one clock edge, then compare all outputs against the expected displayed value and pending flag
    task automatic step(input logic [15:0] d, input logic p);
        logic [1:0] t;
        @(posedge clk);
        @(negedge clk);
        n++;
        t = 2'((n / 4) % 4);
        chk("tr", 32'(tr), 32'(t));
        chk("digit", 32'(digit), 32'((d >> (4 * t)) & 16'hf));
        chk("pend", 32'(pend), 32'(p));
        chk("en", 32'(en), 32'(exp_en(n, on, d)));
    endtask

    task automatic steps(input int k, input logic [15:0] d, input logic p);
        for (int i = 0; i < k; i++) step(d, p);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tr", 32'(tr), 0);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_en", 32'(en), 0);
        rst_n = 1'b1;
        steps(20, 16'h0000, 1'b0);
        ld = 1'b1; val = 16'h1234;
        step(16'h0000, 1'b1);
        ld = 1'b0;
        steps(10, 16'h0000, 1'b1);
        steps(17, 16'h1234, 1'b0);
        ld = 1'b1; val = 16'h1111;
        step(16'h1234, 1'b1);
        val = 16'h5678;
        step(16'h1234, 1'b1);
        ld = 1'b0;
        steps(13, 16'h1234, 1'b1);
        steps(16, 16'h5678, 1'b0);
        ld = 1'b1; val = 16'h0042;
        step(16'h0042, 1'b0);
        ld = 1'b0;
        steps(15, 16'h0042, 1'b0);
        ld = 1'b1; val = 16'h0007;
        step(16'h0007, 1'b0);
        ld = 1'b0;
        steps(15, 16'h0007, 1'b0);
        ld = 1'b1; val = 16'h0000;
        step(16'h0000, 1'b0);
        ld = 1'b0;
        steps(15, 16'h0000, 1'b0);
        on = 1'b0;
        steps(16, 16'h0000, 1'b0);
        on = 1'b1;
        step(16'h0000, 1'b0);
        ld = 1'b1; val = 16'h9999;
        step(16'h0000, 1'b1);
        ld = 1'b0;
        steps(7, 16'h0000, 1'b1);
        chk("pre_rst_tr", 32'(tr), 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tr", 32'(tr), 0);
        chk("mid_rst_pend", 32'(pend), 0);
        chk("mid_rst_digit", 32'(digit), 0);
        chk("mid_rst_en", 32'(en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        steps(20, 16'h0000, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
